// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with a variable-latency memory handshake, wait-state timeout and
// trap state. Define CTRL_PERF_CNT_EN to build the retired-instruction counter (instret).
// Encodings: mem_addr_sel {ADDR_PC=0, ADDR_ALU=1}; mem_funct3_sel {FETCH_INST=0, MEM_FUNCT3=1};
// alu_src1_sel {RS1V=0, PC_CUR=1, PC_OLD=2, ZERO_SRC=3}; alu_src2_sel {RS2V=0, IMM=1, PC_INC=2};
// result_sel {ZERO=0, ALU_RES=1, MEM_RES=2}; alu_op {ADD_OP=0, SLT_OP=1, SLTU_OP=2, FUNCT_OP=3}.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned PERF_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              mem_ready,
    input  logic              trap_ack,
    output logic              mem_req,
    output logic              branch,
    output logic              pc_update,
    output logic              inst_en,
    output logic              reg_wren,
    output logic              mem_wren,
    output logic              mem_addr_sel,
    output logic              mem_funct3_sel,
    output logic [1:0]        alu_src1_sel,
    output logic [1:0]        alu_src2_sel,
    output logic [1:0]        result_sel,
    output logic [1:0]        alu_op,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [PERF_W-1:0] instret
);

    localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    typedef enum logic [3:0] {
        StBoot, StFetch, StDecode, StMemAddr, StExecR, StExecI, StExecLui,
        StMemRead, StMemWrite, StMemWb, StAluWb, StBranch, StJump, StTrap
    } state_t;

    typedef enum logic {ADDR_PC, ADDR_ALU} mem_addr_sel_t;
    typedef enum logic {FETCH_INST, MEM_FUNCT3} mem_funct3_sel_t;
    typedef enum logic [1:0] {RS1V, PC_CUR, PC_OLD, ZERO_SRC} alu_src1_sel_t;
    typedef enum logic [1:0] {RS2V, IMM, PC_INC} alu_src2_sel_t;
    typedef enum logic [1:0] {ZERO, ALU_RES, MEM_RES} result_sel_t;
    typedef enum logic [1:0] {ADD_OP, SLT_OP, SLTU_OP, FUNCT_OP} alu_ops_t;

    state_t              state_q, state_d;
    logic [1:0]          cause_q, cause_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                in_wait, timeout;

    logic                mem_req_q, mem_req_d;
    logic                inst_en_q, inst_en_d;
    logic                pc_update_q, pc_update_d;
    logic                reg_wren_q, reg_wren_d;
    logic                mem_wren_q, mem_wren_d;
    logic                branch_q, branch_d;
    logic                trap_q, trap_d;
    mem_addr_sel_t       mem_addr_sel_q, mem_addr_sel_d;
    mem_funct3_sel_t     mem_funct3_sel_q, mem_funct3_sel_d;
    alu_src1_sel_t       alu_src1_q, alu_src1_d;
    alu_src2_sel_t       alu_src2_q, alu_src2_d;
    result_sel_t         result_sel_q, result_sel_d;
    alu_ops_t            alu_op_q, alu_op_d;

    logic                unused_funct3;
    assign unused_funct3 = ^{funct3[2], funct3[0]};

    assign in_wait = state_q inside {StFetch, StMemRead, StMemWrite};
    assign timeout = in_wait && !mem_ready && (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX));

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            StBoot:     state_d = StFetch;
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpcOp:             state_d = StExecR;
                    OpcOpImm:          state_d = StExecI;
                    OpcAuipc:          state_d = StAluWb;
                    OpcLui:            state_d = StExecLui;
                    OpcLoad, OpcStore: state_d = StMemAddr;
                    OpcBranch:         state_d = StBranch;
                    OpcJal, OpcJalr:   state_d = StJump;
                    default: begin
                        state_d = StTrap;
                        cause_d = 2'b01;
                    end
                endcase
            end
            StMemAddr:  state_d = (opcode == OpcStore) ? StMemWrite : StMemRead;
            StExecR, StExecI, StExecLui, StJump: state_d = StAluWb;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StMemWb, StAluWb, StBranch: state_d = StFetch;
            StTrap: begin
                if (trap_ack) begin
                    state_d = StFetch;
                    cause_d = 2'b00;
                end
            end
            default:    state_d = StBoot;
        endcase
        if (timeout) begin
            state_d = StTrap;
            cause_d = 2'b10;
        end
    end

    // Any state change clears the counter, so every wait state is entered with zero.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (in_wait && !mem_ready && wait_cnt_q != WAIT_W'(MEM_WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Datapath controls are decoded from the state being entered and registered with it.
    always_comb begin
        mem_req_d        = 1'b0;
        inst_en_d        = 1'b0;
        pc_update_d      = 1'b0;
        reg_wren_d       = 1'b0;
        mem_wren_d       = 1'b0;
        branch_d         = 1'b0;
        trap_d           = 1'b0;
        mem_addr_sel_d   = ADDR_PC;
        mem_funct3_sel_d = FETCH_INST;
        alu_src1_d       = RS1V;
        alu_src2_d       = RS2V;
        result_sel_d     = ZERO;
        alu_op_d         = ADD_OP;
        unique case (state_d)
            StFetch: begin
                mem_req_d    = 1'b1;
                inst_en_d    = 1'b1;
                pc_update_d  = 1'b1;
                alu_src1_d   = PC_CUR;
                alu_src2_d   = PC_INC;
                result_sel_d = ALU_RES;
            end
            StDecode: begin
                alu_src1_d = PC_OLD;
                alu_src2_d = IMM;
            end
            StMemAddr: alu_src2_d = IMM;
            StExecR:   alu_op_d = FUNCT_OP;
            StExecI: begin
                alu_src2_d = IMM;
                alu_op_d   = FUNCT_OP;
            end
            StExecLui: begin
                alu_src1_d = ZERO_SRC;
                alu_src2_d = IMM;
            end
            StMemRead, StMemWrite: begin
                mem_req_d        = 1'b1;
                mem_wren_d       = (state_d == StMemWrite);
                mem_addr_sel_d   = ADDR_ALU;
                mem_funct3_sel_d = MEM_FUNCT3;
            end
            StMemWb: begin
                reg_wren_d   = 1'b1;
                result_sel_d = MEM_RES;
            end
            StAluWb: begin
                reg_wren_d   = 1'b1;
                result_sel_d = ALU_RES;
            end
            StBranch: begin
                branch_d = 1'b1;
                alu_op_d = funct3[1] ? SLTU_OP : SLT_OP;
            end
            StJump: begin
                pc_update_d  = 1'b1;
                alu_src1_d   = PC_OLD;
                alu_src2_d   = PC_INC;
                result_sel_d = ALU_RES;
            end
            StTrap:  trap_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StBoot;
            cause_q          <= 2'b00;
            wait_cnt_q       <= '0;
            mem_req_q        <= 1'b0;
            inst_en_q        <= 1'b0;
            pc_update_q      <= 1'b0;
            reg_wren_q       <= 1'b0;
            mem_wren_q       <= 1'b0;
            branch_q         <= 1'b0;
            trap_q           <= 1'b0;
            mem_addr_sel_q   <= ADDR_PC;
            mem_funct3_sel_q <= FETCH_INST;
            alu_src1_q       <= RS1V;
            alu_src2_q       <= RS2V;
            result_sel_q     <= ZERO;
            alu_op_q         <= ADD_OP;
        end else begin
            state_q          <= state_d;
            cause_q          <= cause_d;
            wait_cnt_q       <= wait_cnt_d;
            mem_req_q        <= mem_req_d;
            inst_en_q        <= inst_en_d;
            pc_update_q      <= pc_update_d;
            reg_wren_q       <= reg_wren_d;
            mem_wren_q       <= mem_wren_d;
            branch_q         <= branch_d;
            trap_q           <= trap_d;
            mem_addr_sel_q   <= mem_addr_sel_d;
            mem_funct3_sel_q <= mem_funct3_sel_d;
            alu_src1_q       <= alu_src1_d;
            alu_src2_q       <= alu_src2_d;
            result_sel_q     <= result_sel_d;
            alu_op_q         <= alu_op_d;
        end
    end

    // Wait-state strobes fire only on the completing cycle; the JUMP PC write is unconditional.
    assign mem_req        = mem_req_q;
    assign inst_en        = inst_en_q & mem_ready;
    assign pc_update      = pc_update_q & (mem_ready | (state_q == StJump));
    assign mem_wren       = mem_wren_q & mem_ready;
    assign reg_wren       = reg_wren_q;
    assign branch         = branch_q;
    assign trap           = trap_q;
    assign trap_cause     = cause_q;
    assign mem_addr_sel   = mem_addr_sel_q;
    assign mem_funct3_sel = mem_funct3_sel_q;
    // JALR picks rs1 as its DECODE base once the new opcode is visible in the IR.
    assign alu_src1_sel   = (state_q == StDecode && opcode == OpcJalr) ? RS1V : alu_src1_q;
    assign alu_src2_sel   = alu_src2_q;
    assign result_sel     = result_sel_q;
    assign alu_op         = alu_op_q;

`ifdef CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] instret_q;
    logic              retire;

    assign retire = (state_q inside {StMemWb, StAluWb, StBranch})
                  || (state_q == StMemWrite && mem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + PERF_W'(1);
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction phase model predicts every cycle's
// strobes, trap status, instret and selected mux settings under random opcodes and memory waits.
module tb_multicycle_ctrl;

    localparam int MAX = 15;
    localparam int PW  = 4;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Strobe vector order: {mem_req, inst_en, pc_update, reg_wren, mem_wren, branch, trap}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_REQ  = 7'b1000000;
    localparam logic [6:0] S_JMP  = 7'b0010000;
    localparam logic [6:0] S_WB   = 7'b0001000;
    localparam logic [6:0] S_BR   = 7'b0000010;
    localparam logic [6:0] S_TRAP = 7'b0000001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          mem_ready = 1'b0;
    logic          trap_ack = 1'b0;
    logic          mem_req, branch, pc_update, inst_en, reg_wren, mem_wren;
    logic          mem_addr_sel, mem_funct3_sel, trap;
    logic [1:0]    alu_src1_sel, alu_src2_sel, result_sel, alu_op, trap_cause;
    logic [PW-1:0] instret;

    multicycle_ctrl #(.MEM_WAIT_MAX(MAX), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .trap_ack(trap_ack), .mem_req(mem_req), .branch(branch), .pc_update(pc_update),
        .inst_en(inst_en), .reg_wren(reg_wren), .mem_wren(mem_wren),
        .mem_addr_sel(mem_addr_sel), .mem_funct3_sel(mem_funct3_sel),
        .alu_src1_sel(alu_src1_sel), .alu_src2_sel(alu_src2_sel), .result_sel(result_sel),
        .alu_op(alu_op), .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        ready;
        logic        ack;
        logic [18:0] exp;
        logic [18:0] mask;
    } ent_t;

    ent_t       q[$];
    int         ret_cnt = 0;
    logic [6:0] cur_op = '0;
    logic [2:0] cur_f3 = '0;
    int         checks = 0;
    int         passes = 0;

    function automatic logic [18:0] obs();
        return {mem_req, inst_en, pc_update, reg_wren, mem_wren, branch, trap, trap_cause,
                instret, alu_src1_sel, alu_src2_sel, alu_op};
    endfunction

    function automatic logic [22:0] all_outs();
        return {obs(), mem_addr_sel, mem_funct3_sel, result_sel};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [PW-1:0] exp_instret();
`ifdef CTRL_PERF_CNT_EN
        return PW'(ret_cnt % (1 << PW));
`else
        return '0;
`endif
    endfunction

    // mux = {alu_src1_sel, alu_src2_sel, alu_op}; mmask selects which of those bits are checked
    function automatic void push(input logic rdy, input logic ack, input logic [6:0] stb,
                                 input logic [1:0] cause, input logic [5:0] mux,
                                 input logic [5:0] mmask);
        ent_t e;
        e.op    = cur_op;
        e.f3    = cur_f3;
        e.ready = rdy;
        e.ack   = ack;
        e.exp   = {stb, cause, exp_instret(), mux};
        e.mask  = {13'h1fff, mmask};
        q.push_back(e);
    endfunction

    // Memory access with `zeros` not-ready cycles; more than MAX of them is a bus fault.
    function automatic bit wait_phase(input int zeros, input logic is_fetch, input logic is_store);
        int n0;
        n0 = (zeros > MAX) ? MAX + 1 : zeros;
        for (int k = 0; k < n0; k++) push(1'b0, rb(), S_REQ, 2'b00, '0, '0);
        if (zeros > MAX) return 1'b1;
        push(1'b1, rb(), {1'b1, is_fetch, is_fetch, 1'b0, is_store, 2'b00}, 2'b00, '0, '0);
        return 1'b0;
    endfunction

    function automatic void trap_phase(input logic [1:0] cause);
        push(rb(), 1'b0, S_TRAP, cause, '0, '0);
        push(rb(), 1'b1, S_TRAP, cause, '0, '0);
    endfunction

    function automatic void push_instr(input logic [6:0] op, input logic [2:0] f3,
                                       input int fz, input int mz);
        cur_op = op;
        cur_f3 = f3;
        if (wait_phase(fz, 1'b1, 1'b0)) begin
            trap_phase(2'b10);
            return;
        end
        // DECODE: PC_OLD+IMM, or RS1V+IMM for JALR
        push(rb(), rb(), S_NONE, 2'b00, {(op == OPC_JALR) ? 2'd0 : 2'd2, 2'd1, 2'd0}, 6'h3f);
        case (op)
            OPC_R, OPC_I, OPC_LUI: begin
                push(rb(), rb(), S_NONE, 2'b00, '0, '0);
                push(rb(), rb(), S_WB, 2'b00, '0, '0);
                ret_cnt++;
            end
            OPC_AUIPC: begin
                push(rb(), rb(), S_WB, 2'b00, '0, '0);
                ret_cnt++;
            end
            OPC_JAL, OPC_JALR: begin
                push(rb(), rb(), S_JMP, 2'b00, {2'd2, 2'd2, 2'd0}, 6'h3f);
                push(rb(), rb(), S_WB, 2'b00, '0, '0);
                ret_cnt++;
            end
            OPC_BRANCH: begin
                push(rb(), rb(), S_BR, 2'b00, {4'b0000, f3[1] ? 2'd2 : 2'd1}, 6'h03);
                ret_cnt++;
            end
            OPC_LOAD: begin
                push(rb(), rb(), S_NONE, 2'b00, '0, '0);
                if (wait_phase(mz, 1'b0, 1'b0)) begin
                    trap_phase(2'b10);
                    return;
                end
                push(rb(), rb(), S_WB, 2'b00, '0, '0);
                ret_cnt++;
            end
            OPC_STORE: begin
                push(rb(), rb(), S_NONE, 2'b00, '0, '0);
                if (wait_phase(mz, 1'b0, 1'b1)) begin
                    trap_phase(2'b10);
                    return;
                end
                ret_cnt++;
            end
            default: trap_phase(2'b01);
        endcase
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_outs() !== '0) $display("FAIL reset_hold: got %h expected 0", all_outs());
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) $display("FAIL boot_cycle: got %h expected 0", all_outs());
        else passes++;
    endtask

    task automatic test_add();
        ent_t e;
        int   n = 0;
        q.delete();
        push_instr(OPC_R, 3'b000, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.op; funct3 = e.f3; mem_ready = e.ready; trap_ack = e.ack;
            #1;
            checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask))
                $display("FAIL add cycle %0d: got %b expected %b", n, obs() & e.mask, e.exp);
            else passes++;
            n++;
        end
    endtask

    task automatic test_load_wait();
        ent_t e;
        int   n = 0;
        q.delete();
        push_instr(OPC_LOAD, 3'b010, 2, 3);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.op; funct3 = e.f3; mem_ready = e.ready; trap_ack = e.ack;
            #1;
            checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask))
                $display("FAIL load_wait cycle %0d: got %b expected %b", n, obs() & e.mask, e.exp);
            else passes++;
            n++;
        end
    endtask

    task automatic test_store_timeout();
        ent_t e;
        int   n = 0;
        q.delete();
        push_instr(OPC_STORE, 3'b010, 0, MAX + 1);
        push_instr(OPC_STORE, 3'b010, 0, MAX);
        push_instr(OPC_R, 3'b000, MAX + 1, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.op; funct3 = e.f3; mem_ready = e.ready; trap_ack = e.ack;
            #1;
            checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask))
                $display("FAIL store_timeout cycle %0d: got %b expected %b", n, obs() & e.mask,
                         e.exp);
            else passes++;
            n++;
        end
    endtask

    task automatic test_illegal_trap();
        ent_t e;
        int   n = 0;
        q.delete();
        push_instr(7'b0000000, 3'b000, 0, 0);
        push_instr(7'b1110011, 3'b001, 1, 0);
        push_instr(OPC_JALR, 3'b000, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.op; funct3 = e.f3; mem_ready = e.ready; trap_ack = e.ack;
            #1;
            checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask))
                $display("FAIL illegal cycle %0d: got %b expected %b", n, obs() & e.mask, e.exp);
            else passes++;
            n++;
        end
    endtask

    task automatic test_random();
        ent_t       e;
        int         n = 0;
        logic [6:0] ops [12] = '{OPC_R, OPC_I, OPC_AUIPC, OPC_LUI, OPC_LOAD, OPC_STORE,
                                 OPC_BRANCH, OPC_JAL, OPC_JALR, 7'b0000000, 7'b1110011,
                                 7'b0001111};
        int         r, fz, mz;
        q.delete();
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 19);
            fz = (r < 17) ? r % 3 : ((r < 19) ? MAX : MAX + 1);
            r  = $urandom_range(0, 19);
            mz = (r < 16) ? r % 4 : ((r < 18) ? MAX : MAX + 1);
            push_instr(ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)), fz, mz);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.op; funct3 = e.f3; mem_ready = e.ready; trap_ack = e.ack;
            #1;
            checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask))
                $display("FAIL random cycle %0d op %b: got %b expected %b", n, e.op,
                         obs() & e.mask, e.exp);
            else passes++;
            n++;
        end
    endtask

    task automatic test_reset_mid_access();
        ent_t e;
        q.delete();
        push_instr(OPC_LOAD, 3'b010, 0, 5);
        // fetch, decode, addr, then two not-ready MEM_READ cycles
        for (int i = 0; i < 5; i++) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.op; funct3 = e.f3; mem_ready = e.ready; trap_ack = e.ack;
            #1;
            checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask))
                $display("FAIL reset_mid cycle %0d: got %b expected %b", i, obs() & e.mask,
                         e.exp);
            else passes++;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) $display("FAIL reset_async_drop: got %h expected 0", all_outs());
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) $display("FAIL reset_boot_again: got %h expected 0", all_outs());
        else passes++;
        ret_cnt = 0;
        q.delete();
    endtask

    task automatic test_perf_wrap();
        ent_t          e;
        int            n = 0;
        logic [PW-1:0] want;
        q.delete();
        repeat (17) push_instr(OPC_R, 3'b000, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.op; funct3 = e.f3; mem_ready = e.ready; trap_ack = e.ack;
            #1;
            checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask))
                $display("FAIL perf cycle %0d: got %b expected %b", n, obs() & e.mask, e.exp);
            else passes++;
            n++;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
`ifdef CTRL_PERF_CNT_EN
        want = PW'(1);
`else
        want = '0;
`endif
        checks++;
        if (instret !== want) $display("FAIL instret_17_adds: got %0d expected %0d", instret, want);
        else passes++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_store_timeout();
        test_illegal_trap();
        test_random();
        test_reset_mid_access();
        test_perf_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
